// File: rtl/dmi_req_sched.sv
// dmi_req_sched: shares the single debug-module register port between two
// pulse-protocol requesters (A = JTAG path, B = SoC debug requester).
//
// Each requester has a 1-deep request buffer. Buffered requests are
// arbitrated round-robin. The winner gets a one-cycle dm_en strobe, and the
// block then waits for dm_ack, giving up after TIMEOUT cycles. A one-cycle
// completion (x_rvalid with x_rdata/x_err) goes back to the owning requester.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   x_reg_en          request pulse (x = a|b), qualified by x_reg_wr_en/x_addr/x_wdata
//   x_rvalid/x_rdata  completion pulse; read data is held until the next completion
//   x_err             timeout flag, valid with x_rvalid
//   x_busy            request pending or in flight
//   x_ovf             sticky: a pulse arrived while the buffer was full
//   ovf_clr           clears both overflow flags
//   dm_*              registered debug-module access port, dm_ack/dm_rdata returned

module dmi_req_sched #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_reg_en,
  input  logic              a_reg_wr_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              a_busy,
  output logic              a_ovf,

  input  logic              b_reg_en,
  input  logic              b_reg_wr_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              b_busy,
  output logic              b_ovf,

  input  logic              ovf_clr,

  output logic              dm_en,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 0 = A, 1 = B
  logic              last_q, last_d;    // last granted requester, same encoding
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic              a_wr_q, a_wr_d, b_wr_q, b_wr_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d, b_wdata_q, b_wdata_d;
  logic              a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;

  logic              dm_en_q, dm_en_d, dm_wr_en_q, dm_wr_en_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;

  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic              grant_a, grant_b, a_take, b_take;
  logic              resp_fire, resp_err;
  logic [DATA_W-1:0] resp_data;

  // On a tie, the requester that was not granted last wins.
  assign grant_a = (state_q == StIdle) & pend_a_q & (~pend_b_q | last_q);
  assign grant_b = (state_q == StIdle) & pend_b_q & (~pend_a_q | ~last_q);

  // A buffer being granted this edge frees up in time to accept a new pulse.
  assign a_take = a_reg_en & (~pend_a_q | grant_a);
  assign b_take = b_reg_en & (~pend_b_q | grant_b);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    a_wr_d     = a_wr_q;
    b_wr_d     = b_wr_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    a_wdata_d  = a_wdata_q;
    b_wdata_d  = b_wdata_q;
    a_ovf_d    = a_ovf_q;
    b_ovf_d    = b_ovf_q;
    dm_en_d    = 1'b0;
    dm_wr_en_d = dm_wr_en_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;

    // Request buffers and overflow flags; a new overflow beats ovf_clr.
    if (grant_a) pend_a_d = 1'b0;
    if (grant_b) pend_b_d = 1'b0;
    if (a_take) begin
      pend_a_d  = 1'b1;
      a_wr_d    = a_reg_wr_en;
      a_addr_d  = a_addr;
      a_wdata_d = a_wdata;
    end
    if (b_take) begin
      pend_b_d  = 1'b1;
      b_wr_d    = b_reg_wr_en;
      b_addr_d  = b_addr;
      b_wdata_d = b_wdata;
    end
    if (ovf_clr) begin
      a_ovf_d = 1'b0;
      b_ovf_d = 1'b0;
    end
    if (a_reg_en && !a_take) a_ovf_d = 1'b1;
    if (b_reg_en && !b_take) b_ovf_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (grant_a || grant_b) begin
          state_d    = StIssue;
          owner_d    = grant_b;
          last_d     = grant_b;
          cnt_d      = '0;
          dm_en_d    = 1'b1;
          dm_wr_en_d = grant_b ? b_wr_q : a_wr_q;
          dm_addr_d  = grant_b ? b_addr_q : a_addr_q;
          dm_wdata_d = grant_b ? b_wdata_q : a_wdata_q;
        end
      end
      StIssue: begin
        if (dm_ack) begin
          resp_fire = 1'b1;
          resp_data = dm_wr_en_q ? '0 : dm_rdata;
        end else begin
          state_d = StWait;
          cnt_d   = CntW'(1);
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (dm_ack) begin
          resp_fire = 1'b1;
          resp_data = dm_wr_en_q ? '0 : dm_rdata;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (resp_fire) begin
      state_d = StResp;
      if (!owner_q) begin
        a_rvalid_d = 1'b1;
        a_err_d    = resp_err;
        a_rdata_d  = resp_data;
      end else begin
        b_rvalid_d = 1'b1;
        b_err_d    = resp_err;
        b_rdata_d  = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      a_wr_q     <= 1'b0;
      b_wr_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      a_wdata_q  <= '0;
      b_wdata_q  <= '0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
      dm_en_q    <= 1'b0;
      dm_wr_en_q <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      a_wr_q     <= a_wr_d;
      b_wr_q     <= b_wr_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      a_wdata_q  <= a_wdata_d;
      b_wdata_q  <= b_wdata_d;
      a_ovf_q    <= a_ovf_d;
      b_ovf_q    <= b_ovf_d;
      dm_en_q    <= dm_en_d;
      dm_wr_en_q <= dm_wr_en_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_busy   = pend_a_q | ((state_q != StIdle) & ~owner_q);
  assign b_busy   = pend_b_q | ((state_q != StIdle) & owner_q);
  assign a_ovf    = a_ovf_q;
  assign b_ovf    = b_ovf_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_err    = a_err_q;
  assign b_err    = b_err_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign dm_en    = dm_en_q;
  assign dm_wr_en = dm_wr_en_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_dmi_req_sched.sv
// Self-checking bench for dmi_req_sched. Expected issues and completions are
// queued when stimulus is driven and compared when the DUT strobes dm_en or
// x_rvalid; a small debug-module model answers each issue per a queued plan.

module tb_dmi_req_sched;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 64;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } iss_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct {
    int            dly;    // cycles after the issue cycle, -1 = never ack
    logic [DW-1:0] rdata;
  } plan_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_reg_en, a_reg_wr_en, b_reg_en, b_reg_wr_en, ovf_clr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_rvalid, a_err, a_busy, a_ovf, b_rvalid, b_err, b_busy, b_ovf;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          dm_en, dm_wr_en, dm_ack;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;

  iss_t  iss_q[$];
  rsp_t  a_exp[$], b_exp[$];
  plan_t plan_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cyc = -1, a_rv_cyc = -1, b_rv_cyc = -1;
  int late_ack_cyc = -1;

  dmi_req_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .a_reg_en   (a_reg_en),
    .a_reg_wr_en(a_reg_wr_en),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .a_err      (a_err),
    .a_busy     (a_busy),
    .a_ovf      (a_ovf),
    .b_reg_en   (b_reg_en),
    .b_reg_wr_en(b_reg_wr_en),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .b_err      (b_err),
    .b_busy     (b_busy),
    .b_ovf      (b_ovf),
    .ovf_clr    (ovf_clr),
    .dm_en      (dm_en),
    .dm_wr_en   (dm_wr_en),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_reg_en = 1'b1; a_reg_wr_en = wr; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    b_reg_en = 1'b1; b_reg_wr_en = wr; b_addr = addr; b_wdata = wd;
  endtask

  // Advance one edge with the driven pulses, then drop them.
  task automatic fire();
    tick();
    a_reg_en = 1'b0;
    b_reg_en = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic expect_op(input logic is_b, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] dm_rd,
                           input logic [DW-1:0] exp_rd, input logic exp_err);
    iss_t  i;
    rsp_t  r;
    plan_t p;
    i.wr = wr; i.addr = addr; i.wdata = wd;
    r.rdata = exp_rd; r.err = exp_err;
    p.dly = dly; p.rdata = dm_rd;
    iss_q.push_back(i);
    plan_q.push_back(p);
    if (is_b) b_exp.push_back(r);
    else a_exp.push_back(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy) && n < 300) begin
      tick();
      n++;
    end
    check_eq("idle_within_bound", n < 300, 1);
    ticks(2);
  endtask

  // Debug-module model: answers each dm_en according to the next plan entry.
  initial begin : dm_model
    int            wait_cnt;
    logic [DW-1:0] ack_data;
    plan_t         p;
    wait_cnt = -1;
    ack_data = '0;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      dm_ack = 1'b0;
      if (rst) begin
        wait_cnt = -1;
      end else begin
        if (wait_cnt > 0) wait_cnt--;
        if (dm_en) begin
          check_eq("plan_available", plan_q.size() != 0, 1);
          if (plan_q.size() != 0) begin
            p        = plan_q.pop_front();
            wait_cnt = p.dly;
            ack_data = p.rdata;
          end
        end
        if (wait_cnt == 0) begin
          dm_ack   = 1'b1;
          dm_rdata = ack_data;
          wait_cnt = -1;
        end else if (cyc == late_ack_cyc) begin
          dm_ack   = 1'b1;
          dm_rdata = 32'hBAD0BAD0;
        end
      end
    end
  end

  // Monitor: compares issues and completions against the scoreboard queues.
  initial begin : monitor
    int   prev_en;
    iss_t i;
    rsp_t r;
    prev_en = -1000;
    forever begin
      @(negedge clk);
      if (rst) prev_en = -1000;
      if (dm_en) begin
        check_eq("issue_spacing_ge3", (cyc - prev_en) >= 3, 1);
        prev_en = cyc;
        en_cyc  = cyc;
        check_eq("issue_expected", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) begin
          i = iss_q.pop_front();
          check_eq("dm_wr_en", dm_wr_en, i.wr);
          check_eq("dm_addr", dm_addr, i.addr);
          check_eq("dm_wdata", dm_wdata, i.wdata);
        end
      end
      if (a_rvalid) begin
        a_rv_cyc = cyc;
        check_eq("a_rvalid_expected", a_exp.size() != 0, 1);
        if (a_exp.size() != 0) begin
          r = a_exp.pop_front();
          check_eq("a_rdata", a_rdata, r.rdata);
          check_eq("a_err", a_err, r.err);
        end
      end
      if (b_rvalid) begin
        b_rv_cyc = cyc;
        check_eq("b_rvalid_expected", b_exp.size() != 0, 1);
        if (b_exp.size() != 0) begin
          r = b_exp.pop_front();
          check_eq("b_rdata", b_rdata, r.rdata);
          check_eq("b_err", b_err, r.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    rst = 1'b1;
    a_reg_en = 1'b0; a_reg_wr_en = 1'b0; a_addr = '0; a_wdata = '0;
    b_reg_en = 1'b0; b_reg_wr_en = 1'b0; b_addr = '0; b_wdata = '0;
    ovf_clr = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_dm_en", dm_en, 0);
    check_eq("rst_a_busy", a_busy, 0);
    check_eq("rst_b_busy", b_busy, 0);
    check_eq("rst_a_ovf", a_ovf, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    check_eq("rst_b_rvalid", b_rvalid, 0);

    // Single A read, ack in the issue cycle
    expect_op(0, 0, 7'h11, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    c = cyc;
    drive_a(0, 7'h11, 0);
    fire();
    check_eq("a_busy_after_pulse", a_busy, 1);
    wait_idle();
    check_eq("lat_dm_en", en_cyc - c, 2);
    check_eq("lat_a_rvalid", a_rv_cyc - c, 3);
    check_eq("a_rdata_held", a_rdata, 32'hDEADBEEF);
    check_eq("a_busy_done", a_busy, 0);

    // Simultaneous writes after reset: A first, then B
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
    expect_op(0, 1, 7'h20, 32'h1111, 1, 32'h55, 0, 0);
    expect_op(1, 1, 7'h21, 32'h2222, 1, 32'h55, 0, 0);
    drive_a(1, 7'h20, 32'h1111);
    drive_b(1, 7'h21, 32'h2222);
    fire();
    wait_idle();
    check_eq("b_rdata_write_zero", b_rdata, 0);
    // Single A, then a tie again: B must win now
    expect_op(0, 0, 7'h22, 0, 0, 32'h0A0A0A0A, 32'h0A0A0A0A, 0);
    drive_a(0, 7'h22, 0);
    fire();
    wait_idle();
    expect_op(1, 0, 7'h24, 0, 0, 32'hB2B2B2B2, 32'hB2B2B2B2, 0);
    expect_op(0, 0, 7'h23, 0, 0, 32'hA1A1A1A1, 32'hA1A1A1A1, 0);
    drive_a(0, 7'h23, 0);
    drive_b(0, 7'h24, 0);
    fire();
    wait_idle();

    // Pulse on the grant edge is accepted as a new request
    expect_op(0, 0, 7'h40, 0, 0, 32'h1, 32'h1, 0);
    expect_op(0, 0, 7'h41, 0, 0, 32'h2, 32'h2, 0);
    drive_a(0, 7'h40, 0);
    fire();
    drive_a(0, 7'h41, 0);
    fire();
    check_eq("ovf_grant_edge", a_ovf, 0);
    wait_idle();
    check_eq("a_rdata_second", a_rdata, 32'h2);

    // Overflow while A is pending behind a slow B access
    expect_op(1, 0, 7'h50, 0, 10, 32'hB0B0B0B0, 32'hB0B0B0B0, 0);
    expect_op(0, 1, 7'h30, 32'h3030, 0, 32'h77, 0, 0);
    drive_b(0, 7'h50, 0);
    fire();
    ticks(2);
    drive_a(1, 7'h30, 32'h3030);
    fire();
    tick();
    drive_a(1, 7'h7F, 32'hFFFF);
    fire();
    check_eq("a_ovf_set", a_ovf, 1);
    check_eq("b_ovf_clear", b_ovf, 0);
    drive_a(1, 7'h7E, 32'hEEEE);
    ovf_clr = 1'b1;
    fire();
    check_eq("a_ovf_clr_vs_new", a_ovf, 1);
    ovf_clr = 1'b1;
    fire();
    check_eq("a_ovf_cleared", a_ovf, 0);
    check_eq("a_still_pending", a_busy, 1);
    wait_idle();

    // Timeout: no ack
    expect_op(0, 0, 7'h05, 0, -1, 0, 0, 1);
    drive_a(0, 7'h05, 0);
    fire();
    wait_idle();
    check_eq("timeout_latency", a_rv_cyc - en_cyc, TO);
    check_eq("timeout_rdata", a_rdata, 0);
    expect_op(0, 0, 7'h06, 0, 2, 32'hCAFE0001, 32'hCAFE0001, 0);
    drive_a(0, 7'h06, 0);
    fire();
    wait_idle();
    check_eq("after_timeout_rdata", a_rdata, 32'hCAFE0001);

    // Ack on the last cycle before timeout wins
    expect_op(0, 0, 7'h07, 0, TO - 1, 32'h600DF00D, 32'h600DF00D, 0);
    drive_a(0, 7'h07, 0);
    fire();
    wait_idle();
    check_eq("ack_at_limit_latency", a_rv_cyc - en_cyc, TO);

    // Reset in WAIT with B pending and B overflowed
    begin
      iss_t  i;
      plan_t p;
      i.wr = 0; i.addr = 7'h08; i.wdata = 0;
      p.dly = -1; p.rdata = 0;
      iss_q.push_back(i);
      plan_q.push_back(p);
    end
    drive_a(0, 7'h08, 0);
    fire();
    ticks(5);
    drive_b(0, 7'h09, 0);
    fire();
    drive_b(0, 7'h0A, 0);
    fire();
    check_eq("pre_rst_b_busy", b_busy, 1);
    check_eq("pre_rst_b_ovf", b_ovf, 1);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_dm_en", dm_en, 0);
    check_eq("mid_rst_a_busy", a_busy, 0);
    check_eq("mid_rst_b_busy", b_busy, 0);
    check_eq("mid_rst_b_ovf", b_ovf, 0);
    check_eq("mid_rst_a_rdata", a_rdata, 0);
    rst = 1'b0;
    iss_q.delete();
    plan_q.delete();
    a_exp.delete();
    b_exp.delete();
    late_ack_cyc = cyc + 1;
    ticks(4);
    check_eq("late_ack_a_rdata", a_rdata, 0);
    check_eq("late_ack_a_busy", a_busy, 0);
    check_eq("late_ack_b_busy", b_busy, 0);
    expect_op(0, 0, 7'h0B, 0, 0, 32'h12345678, 32'h12345678, 0);
    c = cyc;
    drive_a(0, 7'h0B, 0);
    fire();
    wait_idle();
    check_eq("post_rst_lat", en_cyc - c, 2);
    check_eq("post_rst_rdata", a_rdata, 32'h12345678);
    check_eq("queues_drained", iss_q.size() + a_exp.size() + b_exp.size() + plan_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
